// File: rtl/instr_entry_pkg.sv
// Shared types and widths for the switch/button instruction entry front-end.
package instr_entry_pkg;

  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 2 * BYTE_W;

  // GET_HI : waiting for the press that captures the high byte
  // GET_LO : high byte held, waiting for the low-byte press
  // HOLD   : complete instruction offered, waiting for the core
  typedef enum logic [1:0] {
    GET_HI = 2'd0,
    GET_LO = 2'd1,
    HOLD   = 2'd2
  } entry_state_t;

endpackage

// File: rtl/instr_entry_unit_debouncer.sv
// Push-button conditioning: two-flop synchronizer, run-length debouncer and
// a one-cycle press pulse on the accepted rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_enable,
  input  logic button,
  output logic press
);

  // The counter only ever holds 0 .. DEBOUNCE_CYCLES-1, so it never wraps.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ;
  logic             reach;

  assign differ = sync_q2 ^ level_q;
  // The count would reach DEBOUNCE_CYCLES on this edge: accept the new level.
  assign reach  = differ && (cnt_q == CNT_LAST);

  // Synchronize, count disagreeing cycles, flip the accepted level on a full run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (clk_enable) begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
      if (!differ || reach) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (reach) begin
        level_q <= sync_q2;
      end
    end
  end

  // Press fires on the same edge the level flips high, so the capture lines up.
  assign press = clk_enable && reach && sync_q2;

endmodule

// File: rtl/instr_entry_unit.sv
// Assembles two debounced switch-byte entries (high first) into one
// instruction and offers it to the core over valid/ready.
module instr_entry_unit
  import instr_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int INSTR_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic [BYTE_W-1:0]  switches,
  input  logic               button,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [INSTR_W-1:0] entry_leds,
  output logic               busy
);

  entry_state_t        state_q, state_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [INSTR_W-1:0]  data_q, data_d;
  logic                press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .button     (button),
    .press      (press)
  );

  // Next-state and byte-capture decisions; presses in HOLD are simply dropped.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    data_d  = data_q;
    unique case (state_q)
      GET_HI: begin
        if (press) begin
          hi_d    = switches;
          lo_d    = '0;
          state_d = GET_LO;
        end
      end
      GET_LO: begin
        if (press) begin
          lo_d    = switches;
          data_d  = {hi_q, switches};
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready && clk_enable) begin
          state_d = GET_HI;
        end
      end
      default: state_d = GET_HI;
    endcase
  end

  // State and byte registers; everything freezes while clk_enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GET_HI;
      hi_q    <= '0;
      lo_q    <= '0;
      data_q  <= '0;
    end else if (clk_enable) begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
    end
  end

  // instr_data is only loaded on the low-byte capture, so it cannot move in HOLD.
  assign instr_valid = (state_q == HOLD);
  assign busy        = (state_q == GET_LO);
  assign instr_data  = data_q;
  assign entry_leds  = {hi_q, lo_q};

endmodule

// File: tb/tb_instr_entry_unit.sv
// Directed and randomized checks of instr_entry_unit against a behavioural model.
module tb_instr_entry_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [7:0]  switches;
  logic        button;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] entry_leds;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int valid_cycles;
  int edges;

  // Behavioural model: history of button samples, run length of disagreement,
  // accepted level, entry phase (0 = high byte, 1 = low byte, 2 = offered).
  bit          samples[$];
  bit          m_level;
  int          m_run;
  int          m_mode;
  logic [7:0]  m_hi;
  logic [7:0]  m_lo;
  logic [15:0] m_data;

  instr_entry_unit #(
    .DEBOUNCE_CYCLES(D),
    .INSTR_W(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .switches    (switches),
    .button      (button),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .entry_leds  (entry_leds),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    samples.delete();
    m_level = 1'b0;
    m_run   = 0;
    m_mode  = 0;
    m_hi    = 8'h00;
    m_lo    = 8'h00;
    m_data  = 16'h0000;
  endfunction

  // A level counts as synchronized two enabled edges after it was sampled;
  // D consecutive disagreeing synchronized edges accept it.
  function automatic void model_edge();
    bit sync;
    bit prs;
    if (!clk_enable) return;
    prs = 1'b0;
    samples.push_back(button);
    sync = (samples.size() >= 3) ? samples[samples.size() - 3] : 1'b0;
    if (samples.size() > 3) void'(samples.pop_front());
    if (sync != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = sync;
        m_run   = 0;
        prs     = sync;
      end
    end else begin
      m_run = 0;
    end
    case (m_mode)
      0: if (prs) begin m_hi = switches; m_lo = 8'h00; m_mode = 1; end
      1: if (prs) begin m_lo = switches; m_data = {m_hi, switches}; m_mode = 2; end
      default: if (instr_ready) m_mode = 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", {15'd0, instr_valid}, {15'd0, (m_mode == 2)});
    chk("busy",  {15'd0, busy},        {15'd0, (m_mode == 1)});
    chk("data",  instr_data, m_data);
    chk("leds",  entry_leds, {m_hi, m_lo});
    if (instr_valid) valid_cycles++;
  endtask

  task automatic press_button(input logic [7:0] sw, input int hold);
    switches = sw;
    button   = 1'b1;
    repeat (hold) tick();
    button   = 1'b0;
    repeat (D + 4) tick();
  endtask

  task automatic tick_r();
    clk_enable  = ($urandom_range(0, 4) != 0);
    instr_ready = $urandom_range(0, 1) == 1;
    tick();
  endtask

  initial begin
    reset       = 1'b0;
    clk_enable  = 1'b1;
    button      = 1'b0;
    instr_ready = 1'b0;
    switches    = 8'h00;
    model_reset();

    // Reset state
    #3;
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_busy",  {15'd0, busy},        16'd0);
    chk("rst_data",  instr_data, 16'h0000);
    chk("rst_leds",  entry_leds, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();

    // Bounce rejection: 3 high, 1 low, 3 high
    switches = 8'hEE;
    button = 1'b1; repeat (3) tick();
    button = 1'b0; tick();
    button = 1'b1; repeat (3) tick();
    button = 1'b0; repeat (D + 4) tick();
    chk("bounce_busy", {15'd0, busy}, 16'd0);
    chk("bounce_leds", entry_leds, 16'h0000);

    // Basic entry with the core ready
    instr_ready  = 1'b1;
    valid_cycles = 0;
    press_button(8'hA5, D + 4);
    chk("basic_busy_hi", {15'd0, busy}, 16'd1);
    chk("basic_leds_hi", entry_leds, 16'hA500);
    press_button(8'h3C, D + 4);
    chk("basic_valid_cycles", 16'(valid_cycles), 16'd1);
    chk("basic_data", instr_data, 16'hA53C);
    chk("basic_leds", entry_leds, 16'hA53C);

    // Backpressure: extra press in HOLD is dropped
    instr_ready = 1'b0;
    press_button(8'hA5, D + 4);
    press_button(8'h3C, D + 4);
    press_button(8'hFF, D + 4);
    chk("bp_valid", {15'd0, instr_valid}, 16'd1);
    chk("bp_data",  instr_data, 16'hA53C);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("bp_done_valid", {15'd0, instr_valid}, 16'd0);
    repeat (3) tick();
    chk("bp_lost_busy", {15'd0, busy}, 16'd0);
    chk("bp_leds", entry_leds, 16'hA53C);

    // Mid-entry asynchronous reset
    press_button(8'h12, D + 4);
    chk("mid_busy_before", {15'd0, busy}, 16'd1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_busy", {15'd0, busy}, 16'd0);
    chk("mid_leds", entry_leds, 16'h0000);
    chk("mid_data", instr_data, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    instr_ready = 1'b1;
    press_button(8'h34, D + 4);
    press_button(8'h56, D + 4);
    chk("mid_result", instr_data, 16'h3456);

    // Enable gating during debounce
    instr_ready = 1'b0;
    switches = 8'h77;
    button = 1'b1;
    edges = 0;
    repeat (2) begin tick(); edges++; end
    clk_enable = 1'b0;
    repeat (10) tick();
    chk("gate_frozen_busy", {15'd0, busy}, 16'd0);
    clk_enable = 1'b1;
    while (!busy && edges < 50) begin tick(); edges++; end
    chk("gate_latency", 16'(edges), 16'(D + 2));
    button = 1'b0;
    repeat (D + 4) tick();
    instr_ready = 1'b1;
    press_button(8'h88, D + 4);
    chk("gate_data", instr_data, 16'h7788);

    // Randomized glitches, presses, enables and backpressure
    for (int n = 0; n < 10; n++) begin
      button = 1'b1;
      repeat ($urandom_range(1, D - 1)) tick_r();
      button = 1'b0;
      repeat ($urandom_range(1, 3)) tick_r();
      switches = 8'($urandom);
      button = 1'b1;
      repeat (D + 2 + $urandom_range(0, 6)) tick_r();
      button = 1'b0;
      repeat (D + 3 + $urandom_range(0, 4)) tick_r();
    end
    clk_enable = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_entry_unit.md
# instr_entry_unit

Front-end that turns the board's 8-bit switch bank and push-button into 16-bit instructions for the processor core. It debounces the button and assembles two successive switch bytes (high byte first) into one instruction. It then offers the instruction over a valid/ready handshake. The unit sits between the board I/O and the datapath's instruction input, mirroring entry progress on the instruction LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive enabled cycles a synchronized button level must hold before it is accepted; minimum 2.
- `INSTR_W`, default 16: instruction width; fixed at 2 × 8.

- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `clk_enable` in 1: global advance qualifier. No state register changes while it is 0.
- `switches` in 8: raw byte from the switch bank. Quasi-static; not synchronized.
- `button` in 1: raw, bouncy, asynchronous push-button.
- `instr_ready` in 1: the core accepts `instr_data` this cycle.
- `instr_valid` out 1: `instr_data` holds a complete instruction.
- `instr_data` out 16: assembled instruction, `{hi_byte, lo_byte}`.
- `entry_leds` out 16: live view of `{hi_byte, lo_byte}` registers.
- `busy` out 1: high byte captured, low byte pending.

## Operation
- **Reset values:** all outputs 0; FSM in `GET_HI`; both byte registers 0x00; debounce counter 0; debounced level 0; synchronizer flops 0.
- **Button path:**
  - Two-flop synchronizer, then the debouncer.
  - Counter increments each enabled cycle while the synchronized level differs from the debounced level. It clears when they are equal.
  - When the counter would reach `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - `press` is the debounced 0→1 transition (one cycle). Releases generate nothing.
- **FSM states:** `GET_HI`, `GET_LO`, `HOLD`.
  - `GET_HI` + press: `hi_byte` ← `switches`; `lo_byte` ← 0x00; go to `GET_LO`.
  - `GET_LO` + press: `lo_byte` ← `switches`; go to `HOLD`.
  - `HOLD`: `instr_valid` = 1. On a cycle with `instr_ready` = 1 and `clk_enable` = 1, the transfer completes and the FSM goes to `GET_HI`. Byte registers are retained until the next high-byte capture.
  - Presses in `HOLD` are dropped, not queued.
- `busy` = 1 exactly in `GET_LO`.
- `instr_data` and `entry_leds` are registered outputs. `instr_data` is stable for the whole time `instr_valid` is high.
- `instr_ready` while not in `HOLD` is ignored.

## Timing
- `button` rising cleanly at edge k gives a synchronized high after edge k+2. The debounced rise and the capture of `switches` both happen at edge k+1+`DEBOUNCE_CYCLES`. Each count assumes `clk_enable` = 1; disabled cycles freeze everything.
- `instr_valid` rises the cycle after the low-byte capture edge.
- Handshake: the transfer happens on the edge where `instr_valid` & `instr_ready` & `clk_enable`. `instr_valid` is 0 the next cycle, so back-to-back instructions are impossible; the minimum gap is two debounced presses.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no press. Any equal-level cycle restarts the count.
- Button held indefinitely gives exactly one press.
- `reset` asserted mid-operation (any state) returns the unit to reset values immediately, without waiting for `clk`. Partially entered bytes are discarded.
- Counter width is `$clog2(DEBOUNCE_CYCLES)` bits. The counter never wraps.

## Structure
- Shared package `instr_entry_pkg`:
  - FSM state enum (`GET_HI`, `GET_LO`, `HOLD`).
  - `BYTE_W` = 8 and `INSTR_W` = 16.
- Sub-module `button_debouncer`:
  - Contains the synchronizer, counter and debounced-level register, parameterized by `DEBOUNCE_CYCLES`.
  - Outputs the one-cycle `press` pulse, gated by `clk_enable`.
- The top holds the FSM and the byte registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `clk_enable` = 1 unless stated.
- **Reset:** assert `reset` = 0 mid-cycle → all outputs 0 asynchronously; FSM `GET_HI`.
- **Basic entry:** switches 0xA5, clean press; then switches 0x3C, clean press; `instr_ready` = 1 → `busy` high after the first capture. `instr_valid` = 1 with `instr_data` = 0xA53C for exactly one cycle, then 0. `entry_leds` stays 0xA53C.
- **Bounce rejection:** button pulses high for 3 cycles, low 1, high 3 → no capture; state stays `GET_HI`; `entry_leds` 0x0000.
- **Backpressure:** complete 0xA53C with `instr_ready` = 0; press again with switches 0xFF → `instr_valid` stays 1 and `instr_data` stays 0xA53C. Raising `instr_ready` completes the transfer; the 0xFF press is lost.
- **Mid-entry reset:** capture high byte 0x12, assert `reset` → `busy` 0 and `entry_leds` 0x0000. The next two presses (0x34, 0x56) yield 0x3456.
- **Enable gating:** during debounce, hold `clk_enable` = 0 for 10 cycles with the button high → no capture until 4 enabled synchronized-high cycles have elapsed.
